// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared state encoding and default widths for the alarm clock controller
// Imported by alarm_clock_ctrl and ring_timer.
package alarm_ctrl_pkg;

  localparam int HR_W_DEF       = 5;
  localparam int MIN_W_DEF      = 6;
  localparam int HR_MAX_DEF     = 24;
  localparam int RING_SECS_DEF  = 30;
  localparam int SNOOZE_MIN_DEF = 5;
  localparam int MIN_WRAP       = 59;

  typedef enum logic [2:0] {
    ST_RUN         = 3'd0,
    ST_SET_HR      = 3'd1,
    ST_SET_MIN     = 3'd2,
    ST_SET_ALM_HR  = 3'd3,
    ST_SET_ALM_MIN = 3'd4
  } state_e;

endpackage

// File: rtl/ring_timer.sv
// rtl/ring_timer.sv - alarm ring flag, ring duration counter and (with SNOOZE_EN) snooze target
// Stop conditions always take priority over a same-cycle ring start.
module ring_timer
  import alarm_ctrl_pkg::*;
#(
  parameter int HR_W      = HR_W_DEF,
  parameter int MIN_W     = MIN_W_DEF,
  parameter int RING_SECS = RING_SECS_DEF
`ifdef SNOOZE_EN
  ,
  parameter int HR_MAX     = HR_MAX_DEF,
  parameter int SNOOZE_MIN = SNOOZE_MIN_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             tick_i,
  input  logic             btn_mode_i,
`ifdef SNOOZE_EN
  input  logic             btn_inc_i,
`endif
  input  logic             alarm_arm_i,
  input  logic [MIN_W-1:0] cur_sec_i,
  input  logic [MIN_W-1:0] cur_min_i,
  input  logic [HR_W-1:0]  cur_hr_i,
  input  logic [MIN_W-1:0] alm_min_i,
  input  logic [HR_W-1:0]  alm_hr_i,
  output logic             ringing_o
);

  localparam int CNT_W = $clog2(RING_SECS + 1);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] RING_FULL = CNT_W'(RING_SECS);

  logic             ringing_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit;
  logic             start;
  logic             stop;
  logic             expire;
  logic             snz_press;

`ifdef SNOOZE_EN
  logic             snz_vld_q;
  logic [HR_W-1:0]  snz_hr_q;
  logic [MIN_W-1:0] snz_min_q;
  logic [HR_W-1:0]  snz_hr_d;
  logic [MIN_W-1:0] snz_min_d;
  logic [MIN_W:0]   snz_sum;

  // Target is alarm time plus the snooze delay, carrying minutes into hours.
  always_comb begin
    snz_sum   = {1'b0, alm_min_i} + (MIN_W + 1)'(SNOOZE_MIN);
    snz_min_d = snz_sum[MIN_W-1:0];
    snz_hr_d  = alm_hr_i;
    if (snz_sum > (MIN_W + 1)'(MIN_WRAP)) begin
      snz_min_d = MIN_W'(snz_sum - (MIN_W + 1)'(MIN_WRAP + 1));
      snz_hr_d  = (alm_hr_i == HR_W'(HR_MAX - 1)) ? '0 : alm_hr_i + 1'b1;
    end
  end

  assign snz_press = ringing_q & btn_inc_i & ~btn_mode_i;
  assign hit = ((cur_hr_i == alm_hr_i) && (cur_min_i == alm_min_i)) ||
               (snz_vld_q && (cur_hr_i == snz_hr_q) && (cur_min_i == snz_min_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snz_vld_q <= 1'b0;
      snz_hr_q  <= '0;
      snz_min_q <= '0;
    end else if (!alarm_arm_i || (ringing_q && btn_mode_i)) begin
      snz_vld_q <= 1'b0;
    end else if (snz_press) begin
      snz_vld_q <= 1'b1;
      snz_hr_q  <= snz_hr_d;
      snz_min_q <= snz_min_d;
    end
  end
`else
  assign snz_press = 1'b0;
  assign hit = (cur_hr_i == alm_hr_i) && (cur_min_i == alm_min_i);
`endif

  // A rollover value (60) can never equal a stored alarm minute or a zero second.
  assign start  = run_i & alarm_arm_i & tick_i & (cur_sec_i == '0) & hit;
  assign expire = ringing_q & tick_i & (cnt_q == RING_LAST);
  assign stop   = btn_mode_i | ~alarm_arm_i | ~run_i | expire | snz_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ringing_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (stop) begin
        ringing_q <= 1'b0;
      end else if (start) begin
        ringing_q <= 1'b1;
      end
      if (start && !stop) begin
        cnt_q <= '0;
      end else if (ringing_q && tick_i && (cnt_q != RING_FULL)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ringing_o = ringing_q;

endmodule

// File: rtl/alarm_clock_ctrl.sv
// rtl/alarm_clock_ctrl.sv - mode FSM, counter enable routing and alarm registers for the alarm clock
// Optional snooze behaviour is enabled with the SNOOZE_EN macro.
module alarm_clock_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int HR_W      = HR_W_DEF,
  parameter int MIN_W     = MIN_W_DEF,
  parameter int HR_MAX    = HR_MAX_DEF,
  parameter int RING_SECS = RING_SECS_DEF
`ifdef SNOOZE_EN
  ,
  parameter int SNOOZE_MIN = SNOOZE_MIN_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             alarm_arm,
  input  logic             sec_zc,
  input  logic             min_zc,
  input  logic [MIN_W-1:0] cur_sec,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [HR_W-1:0]  cur_hr,
  output logic             sec_c,
  output logic             min_c,
  output logic             hr_c,
  output logic             sec_clr,
  output logic [MIN_W-1:0] alm_min,
  output logic [HR_W-1:0]  alm_hr,
  output logic [2:0]       mode,
  output logic             ringing
);

  localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(HR_MAX - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_WRAP);

  state_e           state_q;
  logic             sec_c_q;
  logic             min_c_q;
  logic             hr_c_q;
  logic             sec_clr_q;
  logic [HR_W-1:0]  alm_hr_q;
  logic [HR_W-1:0]  alm_hr_d;
  logic [MIN_W-1:0] alm_min_q;
  logic [MIN_W-1:0] alm_min_d;
  logic             inc;

  // A mode press in the same cycle swallows the increment.
  assign inc       = btn_inc & ~btn_mode;
  assign alm_hr_d  = (alm_hr_q == HR_LAST) ? '0 : alm_hr_q + 1'b1;
  assign alm_min_d = (alm_min_q == MIN_LAST) ? '0 : alm_min_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      sec_c_q   <= 1'b0;
      min_c_q   <= 1'b0;
      hr_c_q    <= 1'b0;
      sec_clr_q <= 1'b0;
      alm_hr_q  <= '0;
      alm_min_q <= '0;
    end else begin
      sec_c_q   <= 1'b0;
      min_c_q   <= 1'b0;
      hr_c_q    <= 1'b0;
      sec_clr_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          sec_c_q <= tick_1hz;
          min_c_q <= sec_zc;
          hr_c_q  <= min_zc;
          // While ringing the mode press only silences the alarm.
          if (btn_mode && !ringing) begin
            state_q   <= ST_SET_HR;
            sec_clr_q <= 1'b1;
          end
        end
        ST_SET_HR: begin
          hr_c_q <= inc;
          if (btn_mode) state_q <= ST_SET_MIN;
        end
        ST_SET_MIN: begin
          min_c_q <= inc;
          if (btn_mode) state_q <= ST_SET_ALM_HR;
        end
        ST_SET_ALM_HR: begin
          if (inc) alm_hr_q <= alm_hr_d;
          if (btn_mode) state_q <= ST_SET_ALM_MIN;
        end
        ST_SET_ALM_MIN: begin
          if (inc) alm_min_q <= alm_min_d;
          if (btn_mode) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  ring_timer #(
    .HR_W      (HR_W),
    .MIN_W     (MIN_W),
    .RING_SECS (RING_SECS)
`ifdef SNOOZE_EN
    ,
    .HR_MAX    (HR_MAX),
    .SNOOZE_MIN(SNOOZE_MIN)
`endif
  ) u_ring_timer (
    .clk        (clk),
    .rst        (rst),
    .run_i      (state_q == ST_RUN),
    .tick_i     (tick_1hz),
    .btn_mode_i (btn_mode),
`ifdef SNOOZE_EN
    .btn_inc_i  (btn_inc),
`endif
    .alarm_arm_i(alarm_arm),
    .cur_sec_i  (cur_sec),
    .cur_min_i  (cur_min),
    .cur_hr_i   (cur_hr),
    .alm_min_i  (alm_min_q),
    .alm_hr_i   (alm_hr_q),
    .ringing_o  (ringing)
  );

  assign sec_c   = sec_c_q;
  assign min_c   = min_c_q;
  assign hr_c    = hr_c_q;
  assign sec_clr = sec_clr_q;
  assign alm_min = alm_min_q;
  assign alm_hr  = alm_hr_q;
  assign mode    = state_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// tb/tb_alarm_clock_ctrl.sv - self-checking bench for alarm_clock_ctrl
// Vector table, directed ring/reset/snooze sequences, then random stimulus against a reference model.
module tb_alarm_clock_ctrl;

  localparam int RING_SECS  = 30;
  localparam int SNOOZE_MIN = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, alarm_arm = 1'b0;
  logic       sec_zc = 1'b0, min_zc = 1'b0;
  logic [5:0] cur_sec = '0, cur_min = '0;
  logic [4:0] cur_hr = '0;
  logic       sec_c, min_c, hr_c, sec_clr, ringing;
  logic [5:0] alm_min;
  logic [4:0] alm_hr;
  logic [2:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_clock_ctrl dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .alarm_arm(alarm_arm), .sec_zc(sec_zc), .min_zc(min_zc), .cur_sec(cur_sec),
    .cur_min(cur_min), .cur_hr(cur_hr), .sec_c(sec_c), .min_c(min_c), .hr_c(hr_c),
    .sec_clr(sec_clr), .alm_min(alm_min), .alm_hr(alm_hr), .mode(mode), .ringing(ringing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] in;      // {tick, mode, inc, sec_zc, min_zc}
    logic [2:0] e_mode;
    logic [3:0] e_pulse; // {sec_c, min_c, hr_c, sec_clr}
  } vec_t;

  vec_t tbl [14];

  // Reference model state
  int m_mode, m_ahr, m_amin, m_rcnt, m_sh, m_sm;
  bit m_ring, m_sv;
  bit e_sec, e_min, e_hr, e_clr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses;
    tick_1hz = 0; btn_mode = 0; btn_inc = 0; sec_zc = 0; min_zc = 0;
  endtask

  task automatic press(input bit m, input bit i, input bit t);
    btn_mode = m; btn_inc = i; tick_1hz = t;
    clk1();
    clear_pulses();
  endtask

  task automatic do_reset;
    rst = 0;
    clear_pulses();
    alarm_arm = 0; cur_sec = 0; cur_min = 0; cur_hr = 0;
    clk1(); clk1();
    rst = 1;
    clk1();
  endtask

  task automatic set_alarm(input int hr, input int mn);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    for (int k = 0; k < hr; k++) press(0, 1, 0);
    press(1, 0, 0);
    for (int k = 0; k < mn; k++) press(0, 1, 0);
    press(1, 0, 0);
  endtask

  task automatic model_step(input bit t, input bit m, input bit i, input bit sz, input bit mz,
                            input bit arm, input int hr, input int mn, input int sc);
    bit start, stop, snz;
    int tot;
    snz = 0;
`ifdef SNOOZE_EN
    snz = m_ring && i && !m;
`endif
    start = (m_mode == 0) && arm && t && (sc == 0) &&
            ((hr == m_ahr && mn == m_amin) || (m_sv && hr == m_sh && mn == m_sm));
    stop  = m || !arm || (m_mode != 0) || snz || (m_ring && t && (m_rcnt + 1 >= RING_SECS));
    e_sec = (m_mode == 0) && t;
    e_min = (m_mode == 0) ? sz : (m_mode == 2 && i && !m);
    e_hr  = (m_mode == 0) ? mz : (m_mode == 1 && i && !m);
    e_clr = (m_mode == 0) && m && !m_ring;
    if (!arm || (m_ring && m)) m_sv = 0;
    else if (snz) begin
      tot  = (m_ahr * 60 + m_amin + SNOOZE_MIN) % (24 * 60);
      m_sv = 1; m_sh = tot / 60; m_sm = tot % 60;
    end
    if (i && !m && m_mode == 3) m_ahr  = (m_ahr + 1) % 24;
    if (i && !m && m_mode == 4) m_amin = (m_amin + 1) % 60;
    if (m && !(m_mode == 0 && m_ring)) m_mode = (m_mode + 1) % 5;
    if (stop) m_ring = 0;
    else if (start) begin m_ring = 1; m_rcnt = 0; end
    else if (m_ring && t) m_rcnt++;
  endtask

  initial begin
    tbl[0]  = '{5'b10000, 3'd0, 4'b1000};
    tbl[1]  = '{5'b00010, 3'd0, 4'b0100};
    tbl[2]  = '{5'b00001, 3'd0, 4'b0010};
    tbl[3]  = '{5'b00000, 3'd0, 4'b0000};
    tbl[4]  = '{5'b01000, 3'd1, 4'b0001};
    tbl[5]  = '{5'b00100, 3'd1, 4'b0010};
    tbl[6]  = '{5'b00100, 3'd1, 4'b0010};
    tbl[7]  = '{5'b00100, 3'd1, 4'b0010};
    tbl[8]  = '{5'b10000, 3'd1, 4'b0000};
    tbl[9]  = '{5'b01000, 3'd2, 4'b0000};
    tbl[10] = '{5'b00100, 3'd2, 4'b0100};
    tbl[11] = '{5'b01100, 3'd3, 4'b0000};
    tbl[12] = '{5'b01000, 3'd4, 4'b0000};
    tbl[13] = '{5'b01000, 3'd0, 4'b0000};

    do_reset();
    check("reset_mode", mode, 0);
    check("reset_pulses", {sec_c, min_c, hr_c, sec_clr}, 0);
    check("reset_alarm", {alm_hr, alm_min}, 0);
    check("reset_ringing", ringing, 0);

    for (int k = 0; k < 14; k++) begin
      {tick_1hz, btn_mode, btn_inc, sec_zc, min_zc} = tbl[k].in;
      clk1();
      clear_pulses();
      check($sformatf("vec%0d_pulses", k), {sec_c, min_c, hr_c, sec_clr}, tbl[k].e_pulse);
      check($sformatf("vec%0d_mode", k), mode, tbl[k].e_mode);
    end

    // alarm register wrap
    do_reset();
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    check("enter_alm_hr", mode, 3);
    for (int k = 0; k < 25; k++) press(0, 1, 0);
    check("alm_hr_wrap", alm_hr, 1);
    press(1, 0, 0);
    for (int k = 0; k < 61; k++) press(0, 1, 0);
    check("alm_min_wrap", alm_min, 1);
    press(1, 0, 0);
    check("back_to_run", mode, 0);

    // ring at 07:30 and auto-stop
    do_reset();
    set_alarm(7, 30);
    check("alarm_0730", {alm_hr, alm_min}, {5'd7, 6'd30});
    alarm_arm = 1; cur_hr = 7; cur_min = 30; cur_sec = 60;
    press(0, 0, 1);
    check("rollover_no_ring", ringing, 0);
    cur_sec = 0;
    press(0, 0, 1);
    check("ring_start", ringing, 1);
    cur_sec = 1;
    for (int k = 0; k < RING_SECS - 1; k++) press(0, 0, 1);
    check("ring_before_expiry", ringing, 1);
    press(0, 0, 1);
    check("ring_expired", ringing, 0);

    // mode press silences without leaving RUN
    cur_sec = 0; press(0, 0, 1); cur_sec = 1;
    for (int k = 0; k < 4; k++) press(0, 0, 1);
    press(1, 0, 0);
    check("mode_stop_ring", {ringing, sec_clr, mode}, 0);
    clk1();
    check("mode_stays_run", mode, 0);

    // disarm stops ring
    cur_sec = 0; press(0, 0, 1);
    check("ring_again", ringing, 1);
    alarm_arm = 0; clk1();
    check("disarm_stop", ringing, 0);
    alarm_arm = 1;

    // start and mode in the same cycle: stop wins, mode advances
    press(1, 0, 1);
    check("start_vs_mode", {ringing, mode}, {1'b0, 3'd1});
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    check("cycle_back", mode, 0);

    // async reset mid-ring and mid-set
    press(0, 0, 1);
    check("ring_pre_reset", ringing, 1);
    rst = 0; #2;
    check("async_rst_ring", {ringing, mode, alm_hr, alm_min}, 0);
    rst = 1; clk1();
    press(1, 0, 0);
    check("set_pre_reset", mode, 1);
    rst = 0; #2;
    check("async_rst_set", mode, 0);
    rst = 1; clk1();

`ifdef SNOOZE_EN
    do_reset();
    set_alarm(23, 58);
    alarm_arm = 1; cur_hr = 23; cur_min = 58; cur_sec = 0;
    press(0, 0, 1);
    check("snz_ring", ringing, 1);
    press(0, 1, 0);
    check("snz_stop", ringing, 0);
    cur_hr = 0; cur_min = 2;
    press(0, 0, 1);
    check("snz_early", ringing, 0);
    cur_min = 3;
    press(0, 0, 1);
    check("snz_refire", ringing, 1);
    check("snz_alarm_kept", {alm_hr, alm_min}, {5'd23, 6'd58});
`endif

    // random stimulus against the reference model
    do_reset();
    m_mode = 0; m_ahr = 0; m_amin = 0; m_rcnt = 0; m_ring = 0; m_sv = 0; m_sh = 0; m_sm = 0;
    for (int k = 0; k < 3000; k++) begin
      int hr, mn, sc, pick;
      bit t, m, i, sz, mz, arm;
      t   = ($urandom_range(0, 1) == 1);
      m   = ($urandom_range(0, 29) == 0);
      i   = ($urandom_range(0, 2) == 0);
      sz  = ($urandom_range(0, 3) == 0);
      mz  = ($urandom_range(0, 3) == 0);
      arm = ($urandom_range(0, 39) != 0);
      pick = $urandom_range(0, 3);
      if (pick < 2) begin hr = m_ahr; mn = m_amin; end
      else if (pick == 2 && m_sv) begin hr = m_sh; mn = m_sm; end
      else begin hr = $urandom_range(0, 23); mn = $urandom_range(0, 60); end
      sc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : 0;
      {tick_1hz, btn_mode, btn_inc, sec_zc, min_zc} = {t, m, i, sz, mz};
      alarm_arm = arm; cur_hr = 5'(hr); cur_min = 6'(mn); cur_sec = 6'(sc);
      model_step(t, m, i, sz, mz, arm, hr, mn, sc);
      clk1();
      clear_pulses();
      check($sformatf("rand%0d", k),
            {sec_c, min_c, hr_c, sec_clr, mode, alm_hr, alm_min, ringing},
            {e_sec, e_min, e_hr, e_clr, 3'(m_mode), 5'(m_ahr), 6'(m_amin), m_ring});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_clock_ctrl.md
Name: alarm_clock_ctrl

Overview:
Mode/sequencing controller for the alarm clock time-keeping datapath (second, minute, hour counters).
- Routes count-enable pulses to the counters: the 1 Hz tick and carry chain in run mode, or user increment pulses in the set modes.
- Owns the alarm hour/minute registers.
- Raises the ring output on an alarm match.
- Sits between the button front-end (synchronised, single-cycle pulses) and the counter bank.

Parameters:
HR_W, 5, hour value width
MIN_W, 6, minute/second value width
HR_MAX, 24, hours per day; alarm hour wraps HR_MAX-1 -> 0
RING_SECS, 30, ring duration in 1 Hz ticks before auto-stop
SNOOZE_MIN, 5, snooze delay in minutes (used only with SNOOZE_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
tick_1hz  in  1  one-cycle pulse once per second
btn_mode  in  1  one-cycle pulse, mode button
btn_inc  in  1  one-cycle pulse, increment button
alarm_arm  in  1  level; alarm enabled while 1
sec_zc  in  1  seconds counter rollover flag (high while count==60)
min_zc  in  1  minutes counter rollover flag
cur_sec  in  MIN_W  current seconds
cur_min  in  MIN_W  current minutes
cur_hr  in  HR_W  current hours
sec_c  out  1  seconds counter count-enable
min_c  out  1  minutes counter count-enable
hr_c  out  1  hours counter count-enable
sec_clr  out  1  one-cycle clear pulse to seconds counter
alm_min  out  MIN_W  alarm minute register
alm_hr  out  HR_W  alarm hour register
mode  out  3  current state encoding
ringing  out  1  alarm sounding

Behaviour:
- Reset (rst=0, async): state RUN (mode=0), all pulse outputs 0, alm_min=0, alm_hr=0, ringing=0, ring counter 0. Takes effect immediately, including mid-set or mid-ring.
- States/encoding: RUN=0, SET_HR=1, SET_MIN=2, SET_ALM_HR=3, SET_ALM_MIN=4.
- btn_mode advances RUN->SET_HR->SET_MIN->SET_ALM_HR->SET_ALM_MIN->RUN, except while ringing (see below).
- All outputs are registered; each pulse appears one cycle after its cause.
- RUN: sec_c<=tick_1hz; min_c<=sec_zc; hr_c<=min_zc. btn_inc ignored, except as snooze when SNOOZE_EN is defined.
- SET_HR: hr_c<=btn_inc. SET_MIN: min_c<=btn_inc. sec_c=0 in every non-RUN state (time frozen).
- sec_clr: one cycle, on the transition RUN->SET_HR.
- SET_ALM_HR: btn_inc increments alm_hr, HR_MAX-1 -> 0.
- SET_ALM_MIN: btn_inc increments alm_min, 59 -> 0.
- btn_mode and btn_inc in the same cycle: mode action wins; inc is dropped.
- Ring start: state==RUN, alarm_arm=1, tick_1hz=1, cur_hr==alm_hr, cur_min==alm_min, cur_sec==0 -> ringing<=1 next cycle, ring counter cleared.
- Ring stop, ringing<=0 on any of:
  - btn_mode: press consumed, state unchanged;
  - alarm_arm=0;
  - ring counter reaches RING_SECS ticks;
  - leaving RUN (cannot occur, since mode is consumed while ringing).
- Ring counter increments on tick_1hz while ringing and saturates at RING_SECS.
- Ring start and stop conditions in the same cycle: stop wins.
- Transient cur_min==60 / cur_sec==60 (rollover cycle) never matches an alarm value.

Optional Feature:
Macro SNOOZE_EN.
- Defined: btn_inc while ringing stops the ring and loads a snooze target (alm time + SNOOZE_MIN minutes, minute wrap carrying into hour, hour wrap at HR_MAX). The ring re-fires at cur_sec==0 of the target. The target is cleared by btn_mode during ring, or by alarm_arm=0. alm_min/alm_hr are unchanged.
- Undefined: btn_inc in RUN is ignored even while ringing; no snooze registers exist.

Decomposition:
- Package alarm_ctrl_pkg: state enum and encodings, HR_W/MIN_W defaults, MIN_WRAP=59 constant.
- Sub-module ring_timer: ring flag, tick counter, stop/saturation logic, and the SNOOZE_EN target registers. The FSM and enable routing stay in alarm_clock_ctrl.

Test Plan:
1. Reset, RUN: tick_1hz pulse -> sec_c=1 exactly one cycle later. sec_zc pulse -> min_c one cycle later. min_zc pulse -> hr_c one cycle later.
2. btn_mode x1 -> mode=1 and sec_clr pulse. btn_inc x3 -> three hr_c pulses. tick_1hz during SET_HR -> sec_c stays 0.
3. Enter SET_ALM_HR, btn_inc x25 with HR_MAX=24 -> alm_hr=1. In SET_ALM_MIN, btn_inc x61 -> alm_min=1.
4. Alarm 07:30, arm=1, drive cur=07:30:00 with tick -> ringing=1. After 30 ticks -> ringing=0. Repeat with btn_mode at tick 5 -> ringing=0, mode stays 0.
5. Same-cycle btn_mode+btn_inc in SET_MIN -> mode=3, no min_c pulse. rst=0 asserted mid-ring -> ringing=0, mode=0 immediately (no clock edge needed).
6. SNOOZE_EN: ring at 23:58, btn_inc -> ringing=0. Re-ring at 00:03:00 (minute and hour wrap).
